priv_trap_sequencer: RTL and testbench

// Priv-block end of the priv<->pipeline interface: consumes hazard-unit exception/ret/wfi reports + interrupt lines,

---
 rtl/priv_trap_sequencer.sv | 158 +++++++++++++++
 tb/tb_priv_trap_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/priv_trap_sequencer.sv
// Trap/return/WFI sequencer: picks one cause, waits for pipeline drain, then strobes CSR updates and a PC redirect.
// Latency: event at cycle N -> insert_pc at N+2 at the earliest; backpressure is the pipe_clear drain handshake.
module priv_trap_sequencer #(
    parameter int RMGMT_W    = 1,
    parameter int RMGMT_BASE = 24
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_fault_insn,
    input  logic               i_mal_insn,
    input  logic               i_illegal_insn,
    input  logic               i_breakpoint,
    input  logic               i_env,
    input  logic               i_mal_l,
    input  logic               i_mal_s,
    input  logic               i_fault_l,
    input  logic               i_fault_s,
    input  logic               i_ex_rmgmt,
    input  logic [RMGMT_W-1:0] i_ex_rmgmt_cause,
    input  logic [31:0]        i_epc,
    input  logic [31:0]        i_badaddr,
    input  logic               i_ret,
    input  logic               i_wfi,
    input  logic               i_pipe_clear,
    input  logic               i_ext_int,
    input  logic               i_soft_int,
    input  logic               i_timer_int,
    input  logic               i_mie_meie,
    input  logic               i_mie_msie,
    input  logic               i_mie_mtie,
    input  logic               i_mstatus_mie,
    input  logic [31:0]        i_mtvec,
    input  logic [31:0]        i_mepc_r,
    output logic               o_intr,
    output logic               o_insert_pc,
    output logic [31:0]        o_priv_pc,
    output logic               o_trap_we,
    output logic               o_ret_we,
    output logic [31:0]        o_mepc_next,
    output logic [31:0]        o_mcause_next,
    output logic [31:0]        o_mtval_next,
    output logic               o_sleeping
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN_T  = 3'd1,
        DRAIN_R  = 3'd2,
        REDIRECT = 3'd3,
        SLEEP    = 3'd4
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_target;
    logic        r_intr, r_insert_pc, r_sleeping;
    logic [31:0] r_priv_pc, r_mepc, r_mcause, r_mtval;

    logic        w_exc, w_tval_sel, w_irq_pend, w_irq_take, w_is_irq;
    logic [31:0] w_exc_code, w_irq_code, w_cause, w_base, w_trap_target;
    logic        w_trap_we, w_ret_we, w_latch_trap, w_latch_ret;

    assign w_irq_pend = (i_ext_int & i_mie_meie) | (i_soft_int & i_mie_msie) | (i_timer_int & i_mie_mtie);
    assign w_irq_take = w_irq_pend & i_mstatus_mie;

    always_comb begin
        w_exc      = 1'b1;
        w_tval_sel = 1'b0;
        w_exc_code = 32'd0;
        if (i_fault_insn)        begin w_exc_code = 32'd1;  w_tval_sel = 1'b1; end
        else if (i_mal_insn)     begin w_exc_code = 32'd0;  w_tval_sel = 1'b1; end
        else if (i_illegal_insn) begin w_exc_code = 32'd2;  end
        else if (i_breakpoint)   begin w_exc_code = 32'd3;  end
        else if (i_env)          begin w_exc_code = 32'd11; end
        else if (i_mal_l)        begin w_exc_code = 32'd4;  w_tval_sel = 1'b1; end
        else if (i_mal_s)        begin w_exc_code = 32'd6;  w_tval_sel = 1'b1; end
        else if (i_fault_l)      begin w_exc_code = 32'd5;  w_tval_sel = 1'b1; end
        else if (i_fault_s)      begin w_exc_code = 32'd7;  w_tval_sel = 1'b1; end
        else if (i_ex_rmgmt)     begin w_exc_code = 32'(RMGMT_BASE) + 32'(i_ex_rmgmt_cause); end
        else                     begin w_exc = 1'b0; end
    end

    always_comb begin
        w_irq_code = 32'd7;
        if (i_ext_int & i_mie_meie)       w_irq_code = 32'd11;
        else if (i_soft_int & i_mie_msie) w_irq_code = 32'd3;
    end

    // Vectored mode only offsets interrupts; exceptions always land on the base.
    assign w_is_irq      = ~w_exc & w_irq_take;
    assign w_cause       = w_exc ? w_exc_code : (32'h8000_0000 | w_irq_code);
    assign w_base        = {i_mtvec[31:2], 2'b00};
    assign w_trap_target = (w_is_irq && i_mtvec[1:0] == 2'b01) ? (w_base + (w_irq_code << 2)) : w_base;

    always_comb begin
        w_next       = r_state;
        w_trap_we    = 1'b0;
        w_ret_we     = 1'b0;
        w_latch_trap = 1'b0;
        w_latch_ret  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_exc | w_irq_take) begin
                    w_latch_trap = 1'b1;
                    w_next       = DRAIN_T;
                end else if (i_ret) begin
                    w_latch_ret = 1'b1;
                    w_next      = DRAIN_R;
                end else if (i_wfi & ~w_irq_pend) begin
                    w_next = SLEEP;
                end
            end
            DRAIN_T: if (i_pipe_clear) begin w_trap_we = 1'b1; w_next = REDIRECT; end
            DRAIN_R: if (i_pipe_clear) begin w_ret_we  = 1'b1; w_next = REDIRECT; end
            REDIRECT: w_next = IDLE;
            SLEEP:    if (w_irq_pend) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state     <= IDLE;
            r_target    <= 32'd0;
            r_mepc      <= 32'd0;
            r_mcause    <= 32'd0;
            r_mtval     <= 32'd0;
            r_intr      <= 1'b0;
            r_insert_pc <= 1'b0;
            r_priv_pc   <= 32'd0;
            r_sleeping  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_intr      <= (w_next == DRAIN_T);
            r_insert_pc <= (w_next == REDIRECT);
            r_priv_pc   <= (w_next == REDIRECT) ? r_target : 32'd0;
            r_sleeping  <= (w_next == SLEEP);
            if (w_latch_trap) begin
                r_target <= w_trap_target;
                r_mepc   <= i_epc;
                r_mcause <= w_cause;
                r_mtval  <= (w_exc & w_tval_sel) ? i_badaddr : 32'd0;
            end else if (w_latch_ret) begin
                r_target <= i_mepc_r;
            end
        end
    end

    assign o_intr        = r_intr;
    assign o_insert_pc   = r_insert_pc;
    assign o_priv_pc     = r_priv_pc;
    assign o_trap_we     = w_trap_we;
    assign o_ret_we      = w_ret_we;
    assign o_mepc_next   = r_mepc;
    assign o_mcause_next = r_mcause;
    assign o_mtval_next  = r_mtval;
    assign o_sleeping    = r_sleeping;

endmodule

// File: tb/tb_priv_trap_sequencer.sv
// Directed bench for priv_trap_sequencer: trap priority, vectored interrupts, mret, WFI and mid-drain reset.
module tb_priv_trap_sequencer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        fault_insn, mal_insn, illegal_insn, breakpoint, env, mal_l, mal_s, fault_l, fault_s;
    logic        ex_rmgmt;
    logic [0:0]  ex_rmgmt_cause;
    logic [31:0] epc, badaddr, mtvec, mepc_r;
    logic        ret, wfi, pipe_clear;
    logic        ext_int, soft_int, timer_int, mie_meie, mie_msie, mie_mtie, mstatus_mie;
    logic        intr, insert_pc, trap_we, ret_we, sleeping;
    logic [31:0] priv_pc, mepc_next, mcause_next, mtval_next;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    priv_trap_sequencer #(.RMGMT_W(1), .RMGMT_BASE(24)) dut (
        .i_clk(clk), .i_nrst(nrst),
        .i_fault_insn(fault_insn), .i_mal_insn(mal_insn), .i_illegal_insn(illegal_insn),
        .i_breakpoint(breakpoint), .i_env(env), .i_mal_l(mal_l), .i_mal_s(mal_s),
        .i_fault_l(fault_l), .i_fault_s(fault_s), .i_ex_rmgmt(ex_rmgmt), .i_ex_rmgmt_cause(ex_rmgmt_cause),
        .i_epc(epc), .i_badaddr(badaddr), .i_ret(ret), .i_wfi(wfi), .i_pipe_clear(pipe_clear),
        .i_ext_int(ext_int), .i_soft_int(soft_int), .i_timer_int(timer_int),
        .i_mie_meie(mie_meie), .i_mie_msie(mie_msie), .i_mie_mtie(mie_mtie), .i_mstatus_mie(mstatus_mie),
        .i_mtvec(mtvec), .i_mepc_r(mepc_r),
        .o_intr(intr), .o_insert_pc(insert_pc), .o_priv_pc(priv_pc), .o_trap_we(trap_we), .o_ret_we(ret_we),
        .o_mepc_next(mepc_next), .o_mcause_next(mcause_next), .o_mtval_next(mtval_next), .o_sleeping(sleeping)
    );

    // Advance one clock; inputs are then changed #1 after the edge and outputs read #2 after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        {fault_insn, mal_insn, illegal_insn, breakpoint, env, mal_l, mal_s, fault_l, fault_s} = '0;
        ex_rmgmt = 0; ex_rmgmt_cause = '0; ret = 0; wfi = 0; pipe_clear = 0;
        ext_int = 0; soft_int = 0; timer_int = 0;
    endtask

    task automatic test_reset();
        clear_events();
        epc = 0; badaddr = 0; mtvec = 0; mepc_r = 0;
        mie_meie = 0; mie_msie = 0; mie_mtie = 0; mstatus_mie = 0;
        nrst = 0;
        tick(); tick();
        #1;
        n_cmp++; if ({intr, insert_pc, trap_we, ret_we, sleeping} !== 5'b0) begin n_err++; $display("FAIL reset_strobes got=%b exp=00000", {intr, insert_pc, trap_we, ret_we, sleeping}); end
        n_cmp++; if ({priv_pc, mepc_next, mcause_next, mtval_next} !== 128'd0) begin n_err++; $display("FAIL reset_data got=%h exp=0", {priv_pc, mepc_next, mcause_next, mtval_next}); end
        nrst = 1;
        tick();
    endtask

    task automatic test_priority();
        illegal_insn = 1; mal_l = 1; epc = 32'h200; badaddr = 32'h1003; mtvec = 32'h100;
        tick();
        clear_events(); pipe_clear = 1;
        #1;
        n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL prio_intr got=%b exp=1", intr); end
        n_cmp++; if (mcause_next !== 32'd2) begin n_err++; $display("FAIL prio_mcause got=%h exp=2", mcause_next); end
        n_cmp++; if (mtval_next !== 32'd0) begin n_err++; $display("FAIL prio_mtval got=%h exp=0", mtval_next); end
        n_cmp++; if (mepc_next !== 32'h200) begin n_err++; $display("FAIL prio_mepc got=%h exp=200", mepc_next); end
        n_cmp++; if (trap_we !== 1'b1) begin n_err++; $display("FAIL prio_trap_we got=%b exp=1", trap_we); end
        tick();
        pipe_clear = 0;
        #1;
        n_cmp++; if (insert_pc !== 1'b1 || priv_pc !== 32'h100) begin n_err++; $display("FAIL prio_redirect got=%b/%h exp=1/100", insert_pc, priv_pc); end
        n_cmp++; if (intr !== 1'b0 || trap_we !== 1'b0) begin n_err++; $display("FAIL prio_redirect_intr got=%b/%b exp=0/0", intr, trap_we); end
        tick();
        #1;
        n_cmp++; if (insert_pc !== 1'b0 || priv_pc !== 32'd0) begin n_err++; $display("FAIL prio_one_cycle got=%b/%h exp=0/0", insert_pc, priv_pc); end
    endtask

    task automatic test_mtval();
        fault_s = 1; epc = 32'h44; badaddr = 32'hDEAD_BEEF; mtvec = 32'h101;
        tick();
        clear_events(); pipe_clear = 1;
        tick();
        pipe_clear = 0;
        #1;
        n_cmp++; if (mcause_next !== 32'd7 || mtval_next !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mtval_fault_s got=%h/%h exp=7/deadbeef", mcause_next, mtval_next); end
        n_cmp++; if (insert_pc !== 1'b1 || priv_pc !== 32'h100) begin n_err++; $display("FAIL mtval_target got=%b/%h exp=1/100", insert_pc, priv_pc); end
        tick();
    endtask

    task automatic test_timer_irq();
        timer_int = 1; mie_mtie = 1; mstatus_mie = 1; mtvec = 32'h101; epc = 32'h400;
        tick();
        timer_int = 0;
        for (int i = 0; i < 3; i++) begin
            pipe_clear = (i == 2);
            #1;
            n_cmp++; if (intr !== 1'b1 || insert_pc !== 1'b0) begin n_err++; $display("FAIL irq_drain%0d got=%b/%b exp=1/0", i, intr, insert_pc); end
            tick();
        end
        pipe_clear = 0;
        #1;
        n_cmp++; if (mcause_next !== 32'h8000_0007 || mtval_next !== 32'd0 || mepc_next !== 32'h400) begin n_err++; $display("FAIL irq_csr got=%h/%h/%h exp=80000007/0/400", mcause_next, mtval_next, mepc_next); end
        n_cmp++; if (insert_pc !== 1'b1 || priv_pc !== 32'h11C || intr !== 1'b0) begin n_err++; $display("FAIL irq_redirect got=%b/%h/%b exp=1/11c/0", insert_pc, priv_pc, intr); end
        tick();
        #1;
        n_cmp++; if (insert_pc !== 1'b0) begin n_err++; $display("FAIL irq_one_cycle got=%b exp=0", insert_pc); end
        mie_mtie = 0; mstatus_mie = 0;
    endtask

    task automatic test_ret();
        ret = 1; mepc_r = 32'h8000_0040;
        tick();
        ret = 0; pipe_clear = 1;
        #1;
        n_cmp++; if (intr !== 1'b0 || ret_we !== 1'b1 || trap_we !== 1'b0) begin n_err++; $display("FAIL ret_drain got=%b/%b/%b exp=0/1/0", intr, ret_we, trap_we); end
        tick();
        pipe_clear = 0;
        #1;
        n_cmp++; if (insert_pc !== 1'b1 || priv_pc !== 32'h8000_0040 || ret_we !== 1'b0) begin n_err++; $display("FAIL ret_redirect got=%b/%h/%b exp=1/80000040/0", insert_pc, priv_pc, ret_we); end
        tick();
    endtask

    task automatic test_wfi();
        wfi = 1;
        tick();
        wfi = 0; ret = 1; illegal_insn = 1;
        #1;
        n_cmp++; if (sleeping !== 1'b1) begin n_err++; $display("FAIL wfi_sleep got=%b exp=1", sleeping); end
        tick();
        clear_events();
        #1;
        n_cmp++; if (sleeping !== 1'b1 || intr !== 1'b0) begin n_err++; $display("FAIL wfi_ignore got=%b/%b exp=1/0", sleeping, intr); end
        soft_int = 1; mie_msie = 1; mstatus_mie = 0;
        tick();
        #1;
        n_cmp++; if (sleeping !== 1'b0 || intr !== 1'b0) begin n_err++; $display("FAIL wfi_wake got=%b/%b exp=0/0", sleeping, intr); end
        wfi = 1;
        tick();
        #1;
        n_cmp++; if (sleeping !== 1'b0 || intr !== 1'b0 || insert_pc !== 1'b0) begin n_err++; $display("FAIL wfi_nop got=%b/%b/%b exp=0/0/0", sleeping, intr, insert_pc); end
        clear_events(); mie_msie = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        ret = 1; ex_rmgmt = 1; ex_rmgmt_cause = 1'b0; epc = 32'h300; mtvec = 32'h100; mepc_r = 32'h5550;
        tick();
        clear_events(); breakpoint = 1; epc = 32'h999;
        #1;
        n_cmp++; if (intr !== 1'b1 || mcause_next !== 32'd24) begin n_err++; $display("FAIL b2b_rmgmt got=%b/%h exp=1/18", intr, mcause_next); end
        tick();
        breakpoint = 0; pipe_clear = 1;
        #1;
        n_cmp++; if (mcause_next !== 32'd24 || mepc_next !== 32'h300 || trap_we !== 1'b1) begin n_err++; $display("FAIL b2b_hold got=%h/%h/%b exp=18/300/1", mcause_next, mepc_next, trap_we); end
        tick();
        pipe_clear = 0;
        #1;
        n_cmp++; if (insert_pc !== 1'b1 || priv_pc !== 32'h100) begin n_err++; $display("FAIL b2b_redirect got=%b/%h exp=1/100", insert_pc, priv_pc); end
        tick();
    endtask

    task automatic test_reset_drain();
        illegal_insn = 1; epc = 32'h700;
        tick();
        illegal_insn = 0;
        #1;
        n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL rst_pre_intr got=%b exp=1", intr); end
        nrst = 0;
        tick();
        nrst = 1; pipe_clear = 1;
        #1;
        n_cmp++; if ({intr, insert_pc, trap_we, sleeping} !== 4'b0 || {priv_pc, mcause_next, mepc_next} !== 96'd0) begin n_err++; $display("FAIL rst_drain got=%b/%h exp=0/0", {intr, insert_pc, trap_we, sleeping}, {priv_pc, mcause_next, mepc_next}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            n_cmp++; if (insert_pc !== 1'b0 || intr !== 1'b0) begin n_err++; $display("FAIL rst_no_redirect%0d got=%b/%b exp=0/0", i, insert_pc, intr); end
        end
        pipe_clear = 0;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_mtval();
        test_timer_irq();
        test_ret();
        test_wfi();
        test_back_to_back();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
